// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg
//   Shared definitions for the multiply/divide sequencer: FSM state
//   encodings, divide iteration count, divide-by-zero quotient pattern and
//   the mulOrdiv encoding used for the op_div select.
package mdu_sched_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  localparam int          MDU_DIV_CYCLES = 32;
  localparam logic [31:0] MDU_DIVZ_LO    = 32'hFFFF_FFFF;

  localparam logic mulOrdiv_MUL = 1'b0;
  localparam logic mulOrdiv_DIV = 1'b1;

endpackage

// File: rtl/mdu_sched_if.sv
// mdu_sched_if
//   EX-stage <-> multiply/divide sequencer bundle.
//   master (EX side): start, op_div, is_sign, src_a, src_b, flush, res_ack
//                     out; stall_o, res_valid, hi_o, lo_o in.
//   slave  (mdu_sched): the mirror image.
interface mdu_sched_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              op_div;
  logic              is_sign;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              res_ack;
  logic              stall_o;
  logic              res_valid;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start, op_div, is_sign, src_a, src_b, flush, res_ack,
    input  stall_o, res_valid, hi_o, lo_o
  );

  modport slave (
    input  start, op_div, is_sign, src_a, src_b, flush, res_ack,
    output stall_o, res_valid, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_sched_div_radix2.sv
// mdu_sched_div_radix2
//   Restoring radix-2 divider datapath over unsigned operands. One quotient
//   bit per step_i. The next-step quotient/remainder are exposed
//   combinationally so the owner can capture the final result in the same
//   cycle as the last step.
//   Ports: clk, rst_n (async, active-low), load_i (capture operands),
//          step_i (advance one bit), dividend_i, divisor_i,
//          quo_nxt_o, rem_nxt_o (values after the current step).
module mdu_sched_div_radix2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quo_nxt_o,
  output logic [DATA_W-1:0] rem_nxt_o
);

  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [DATA_W:0]   shifted, diff;
  logic              fits;

  // Dividend bits are shifted out of the quotient register MSB-first into the
  // partial remainder; the vacated LSBs collect quotient bits.
  always_comb begin
    shifted   = {rem_q, quo_q[DATA_W-1]};
    diff      = shifted - {1'b0, dvs_q};
    fits      = ~diff[DATA_W];
    rem_nxt_o = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_nxt_o = {quo_q[DATA_W-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// mdu_sched
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage. Launches on
//   start, stalls IF..EX while running, and holds the HI/LO result with
//   res_valid until EX advances (res_ack). flush cancels without writing HI/LO.
//   Ports: clk, resetn (async, active-low), bus (mdu_sched_if.slave):
//          start/op_div/is_sign/src_a/src_b/flush/res_ack in,
//          stall_o/res_valid/hi_o/lo_o out.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  mdu_sched_if.slave  bus
);

  localparam int CNT_MAX = (MUL_LAT > MDU_DIV_CYCLES) ? MUL_LAT : MDU_DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic              sign_q, sign_d, div_q, div_d;
  logic              load, step;
  logic [DATA_W-1:0] quo_nxt, rem_nxt, q_fix, r_fix;
  logic [2*DATA_W-1:0] prod;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  // Sign- or zero-extend both operands to full width; the truncated product
  // is then correct for either signedness.
  function automatic logic [2*DATA_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic sgn);
    logic [2*DATA_W-1:0] ax, bx;
    ax = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    bx = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  mdu_sched_div_radix2 #(.DATA_W(DATA_W)) u_div (
    .clk        (clk),
    .rst_n      (resetn),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (abs_val(bus.src_a, bus.is_sign)),
    .divisor_i  (abs_val(bus.src_b, bus.is_sign)),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    prod  = mul_ext(a_q, b_q, sign_q);
    q_fix = (sign_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1])) ? -quo_nxt : quo_nxt;
    r_fix = (sign_q && a_q[DATA_W-1]) ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      MDU_IDLE: begin
        if (bus.start && !bus.flush) begin
          load   = 1'b1;
          a_d    = bus.src_a;
          b_d    = bus.src_b;
          sign_d = bus.is_sign;
          div_d  = bus.op_div;
          if (bus.op_div == mulOrdiv_DIV) begin
            state_d = MDU_DIV;
            cnt_d   = CNT_W'(MDU_DIV_CYCLES);
          end else begin
            state_d = MDU_MUL;
            cnt_d   = CNT_W'(MUL_LAT);
          end
        end
      end
      MDU_MUL: begin
        if (bus.flush) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = prod[2*DATA_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
          state_d = MDU_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MDU_DIV: begin
        step = div_q && !bus.flush;
        if (bus.flush) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          // Divide by zero still runs the full iteration count but reports
          // the dividend in HI and all-ones in LO regardless of signedness.
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
          state_d = MDU_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MDU_DONE: begin
        if (bus.flush || bus.res_ack) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // stall drops in DONE so EX can advance in the same cycle res_valid is seen.
  assign bus.stall_o   = bus.start && !bus.flush && (state_q != MDU_DONE);
  assign bus.res_valid = (state_q == MDU_DONE);
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  mdu_sched_if #(.DATA_W(32)) bus ();

  mdu_sched #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Launch in the current cycle (cycle 0) and expect res_valid in cycle lat.
  task automatic run_op(input string tag, input logic sgn, input logic div,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bus.start   = 1'b1;
    bus.op_div  = div;
    bus.is_sign = sgn;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.res_ack = 1'b0;
    bus.flush   = 1'b0;
    #1;
    chk({tag, "_stall_c0"}, bus.stall_o, 1);
    for (int i = 1; i < lat; i++) begin
      cyc();
      if (i == 1) begin
        bus.src_a = ~a;
        bus.src_b = b + 32'd3;
      end
      if (i == lat - 1) begin
        #1;
        chk({tag, "_valid_early"}, bus.res_valid, 0);
        chk({tag, "_stall_busy"}, bus.stall_o, 1);
      end
    end
    cyc();
    #1;
    chk({tag, "_valid"}, bus.res_valid, 1);
    chk({tag, "_stall_done"}, bus.stall_o, 0);
    chk({tag, "_hi"}, bus.hi_o, ehi);
    chk({tag, "_lo"}, bus.lo_o, elo);
    bus.res_ack = 1'b1;
    bus.start   = 1'b0;
    cyc();
    bus.res_ack = 1'b0;
    #1;
    chk({tag, "_valid_cleared"}, bus.res_valid, 0);
  endtask

  initial begin
    logic rose;
    checks      = 0;
    failures    = 0;
    resetn      = 1'b0;
    bus.start   = 1'b0;
    bus.op_div  = 1'b0;
    bus.is_sign = 1'b0;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.flush   = 1'b0;
    bus.res_ack = 1'b0;

    // Reset state
    repeat (2) cyc();
    #1;
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_hi", bus.hi_o, 0);
    chk("rst_lo", bus.lo_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    resetn = 1'b1;
    cyc();

    // MULTU 0xFFFFFFFF x 2, held in DONE for 5 cycles, then back-to-back MULT
    bus.start = 1'b1; bus.op_div = 1'b0; bus.is_sign = 1'b0;
    bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'h2;
    #1;
    chk("mulu_c0_stall", bus.stall_o, 1);
    chk("mulu_c0_valid", bus.res_valid, 0);
    cyc();
    bus.src_a = 32'h0; bus.src_b = 32'h0;
    #1;
    chk("mulu_c1_stall", bus.stall_o, 1);
    cyc();
    #1;
    chk("mulu_c2_stall", bus.stall_o, 1);
    chk("mulu_c2_valid", bus.res_valid, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk("mulu_hold_valid", bus.res_valid, 1);
      chk("mulu_hold_stall", bus.stall_o, 0);
      chk("mulu_hold_hi", bus.hi_o, 32'h0000_0001);
      chk("mulu_hold_lo", bus.lo_o, 32'hFFFF_FFFE);
    end
    cyc();
    bus.res_ack = 1'b1; bus.is_sign = 1'b1;
    bus.src_a = 32'hFFFF_FFFD; bus.src_b = 32'h5;
    #1;
    chk("mulu_ack_valid", bus.res_valid, 1);
    chk("mulu_ack_lo", bus.lo_o, 32'hFFFF_FFFE);
    cyc();
    bus.res_ack = 1'b0;
    #1;
    chk("mul2_idle_valid", bus.res_valid, 0);
    chk("mul2_launch_stall", bus.stall_o, 1);
    cyc();
    cyc();
    #1;
    chk("mul2_c2_valid", bus.res_valid, 0);
    cyc();
    #1;
    chk("mul2_valid", bus.res_valid, 1);
    chk("mul2_hi", bus.hi_o, 32'hFFFF_FFFF);
    chk("mul2_lo", bus.lo_o, 32'hFFFF_FFF1);
    bus.res_ack = 1'b1; bus.start = 1'b0;
    cyc();
    bus.res_ack = 1'b0;
    #1;
    chk("mul2_cleared", bus.res_valid, 0);
    chk("mul2_idle_stall", bus.stall_o, 0);

    // Divides
    run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("divu_by0", 1'b0, 1'b1, 32'h1234_5678, 32'h0, 33, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_by0", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

    // Flush in DIV cycle 10, then flush+start in IDLE must not launch
    bus.start = 1'b1; bus.op_div = 1'b1; bus.is_sign = 1'b0;
    bus.src_a = 32'd100; bus.src_b = 32'd7;
    for (int i = 1; i <= 10; i++) cyc();
    bus.flush = 1'b1;
    #1;
    chk("flush_c10_stall", bus.stall_o, 0);
    cyc();
    #1;
    chk("flush_idle_valid", bus.res_valid, 0);
    chk("flush_idle_stall", bus.stall_o, 0);
    chk("flush_hi_kept", bus.hi_o, 32'h0);
    chk("flush_lo_kept", bus.lo_o, 32'h8000_0000);
    cyc();
    bus.flush = 1'b0; bus.start = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      #1;
      if (bus.res_valid !== 1'b0) rose = 1'b1;
    end
    chk("flush_no_valid", rose, 0);
    chk("flush_lo_final", bus.lo_o, 32'h8000_0000);

    // Asynchronous reset mid-MUL
    bus.start = 1'b1; bus.op_div = 1'b0; bus.is_sign = 1'b0;
    bus.src_a = 32'd3; bus.src_b = 32'd4;
    cyc();
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", bus.res_valid, 0);
    chk("arst_hi", bus.hi_o, 0);
    chk("arst_lo", bus.lo_o, 0);
    bus.start = 1'b0;
    cyc();
    resetn = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      if (bus.res_valid !== 1'b0 || bus.lo_o !== 32'h0) rose = 1'b1;
    end
    chk("arst_no_partial", rose, 0);
    run_op("divu_9_3", 1'b0, 1'b1, 32'd9, 32'd3, 33, 32'd0, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
Multi-cycle multiply/divide sequencer in the EX stage. It launches MULT/MULTU/DIV/DIVU when the decoder raises mdToHilo, stalls the pipeline while the operation runs, and returns a 64-bit HI/LO result with a valid flag. The result is held until EX advances. An exception flush cancels an in-flight operation so that HI/LO are never written.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W.
MUL_LAT, 2, cycles spent in MUL state (≥1).

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  EX holds a valid mult/div instruction (mdToHilo & EX valid)
op_div  in  1  1 = divide, 0 = multiply (mulOrdiv encoding)
is_sign  in  1  signed operation (mdIsSign)
src_a  in  DATA_W  rs value: multiplicand or dividend
src_b  in  DATA_W  rt value: multiplier or divisor
flush  in  1  pipeline flush (exception or eret); cancels the operation
res_ack  in  1  EX advances this cycle (no other stall source)
stall_o  out  1  hold IF..EX
res_valid  out  1  hi_o/lo_o are valid for the instruction currently in EX
hi_o  out  DATA_W  HI result (product[63:32] or remainder)
lo_o  out  DATA_W  LO result (product[31:0] or quotient)

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, counter=0, res_valid=0, hi_o=lo_o=0, internal operand registers=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & ~flush latches src_a, src_b, is_sign and op_div.
  - Next state is DIV with cnt=32 when op_div=1, otherwise MUL with cnt=MUL_LAT.
- MUL: cnt decrements each cycle. When cnt==1, register the 64-bit product into hi_o/lo_o and go to DONE.
  - Signed: product of the two's-complement operands.
  - Unsigned: zero-extended product.
- DIV: restoring radix-2, one quotient bit per cycle over |a| and |b| (absolute values when is_sign=1). When cnt==1, apply the sign fix, register the result and go to DONE.
  - Sign fix: quotient negated if a[31]^b[31]; remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0.
  - Divisor 0 (either signedness): still 32 cycles; HI=src_a latched, LO=0xFFFFFFFF.
- DONE: res_valid=1.
  - res_ack=1 → IDLE next cycle.
  - res_ack=0 → hold DONE; hi_o/lo_o stay stable.
- stall_o (combinational) = start & ~flush & (state != DONE).
  - Asserted in the launch cycle.
  - Deasserted exactly in the cycle res_valid=1.
- Latency from the launch cycle (cycle 0): divide gives res_valid in cycle 33; multiply gives res_valid in cycle MUL_LAT+1.
- After DONE→IDLE, start is re-evaluated the next cycle. A back-to-back mult/div launches with no idle gap beyond that single IDLE cycle.
- flush in any state:
  - Next state is IDLE and res_valid=0 next cycle.
  - No result is registered; flush overrides res_ack and any cnt==1 completion.
  - flush & start in IDLE does not launch.
- Changes on src_a/src_b after launch are ignored; only the latched operands are used.
- Reset asserted mid-operation aborts immediately; no partial result becomes visible.
- hi_o/lo_o keep their last value outside DONE. Consumers qualify them with res_valid.

Decomposition:
- Shared header (alongside control_signal_define.vh):
  - state encodings MDU_IDLE/MUL/DIV/DONE;
  - MDU_DIV_CYCLES=32;
  - MDU_DIVZ_LO=32'hFFFFFFFF;
  - reuse of mulOrdiv_MUL/mulOrdiv_DIV for op_div.
- Sub-module div_radix2: the iterative restoring divider datapath (partial remainder, quotient shift register, one step per enable). mdu_sched owns the FSM, counters, sign handling and multiply.

Test Plan:
- Unsigned MULTU 0xFFFFFFFF×0x2, MUL_LAT=2 → stall_o high for cycles 0–2, res_valid in cycle 3, HI=0x00000001, LO=0xFFFFFFFE.
- Signed DIV −7/2 → res_valid in cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2.
- DIV by zero, src_a=0x12345678 → cycle 33: HI=0x12345678, LO=0xFFFFFFFF; signed 0x80000000/−1 → LO=0x80000000, HI=0.
- flush asserted in DIV cycle 10 → IDLE next cycle, res_valid never rises, stall_o low, hi_o/lo_o unchanged.
- res_ack held low for 5 cycles in DONE → res_valid and HI/LO stable for all 5 cycles; IDLE one cycle after ack; an immediate second MULT launches correctly.
- resetn pulsed low mid-MUL → asynchronous clear of all outputs; a subsequent DIVU 9/3 gives LO=3, HI=0.
